// File: rtl/popcount_pkg.sv
// Shared helpers for the popcount stream: width derivation and beat mode encoding.
package popcount_pkg;

  localparam logic MODE_WORD  = 1'b0;
  localparam logic MODE_FRAME = 1'b1;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int width, input int max_beats);
    return clog2(width * max_beats + 1);
  endfunction

  function automatic int beat_width(input int max_beats);
    return clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of N bits: full-adder leaves of up to three bits,
// with halves merged by ripple chains of full-adder cells.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]             i_bits,
  output logic [clog2(N+1)-1:0]    o_count
);

  localparam int W = clog2(N + 1);

  genvar gi;
  generate
    if (N == 1) begin : g_single
      assign o_count = i_bits;
    end else if (N <= 3) begin : g_leaf
      logic [2:0] w_b;
      assign w_b = 3'(i_bits);
      assign o_count = {(w_b[0] & w_b[1]) | (w_b[0] & w_b[2]) | (w_b[1] & w_b[2]),
                        w_b[0] ^ w_b[1] ^ w_b[2]};
    end else begin : g_node
      localparam int NA = N / 2;
      localparam int NB = N - NA;
      localparam int WA = clog2(NA + 1);
      localparam int WB = clog2(NB + 1);

      logic [WA-1:0] w_cnt_lo;
      logic [WB-1:0] w_cnt_hi;
      logic [W-1:0]  w_a;
      logic [W-1:0]  w_b;
      logic [W-1:0]  w_c;

      popcount_chunk #(.N(NA)) u_lo (.i_bits(i_bits[NA-1:0]), .o_count(w_cnt_lo));
      popcount_chunk #(.N(NB)) u_hi (.i_bits(i_bits[N-1:NA]), .o_count(w_cnt_hi));

      assign w_a    = W'(w_cnt_lo);
      assign w_b    = W'(w_cnt_hi);
      assign w_c[0] = 1'b0;

      // The sum never exceeds N, so the carry out of the top cell is always zero.
      for (gi = 0; gi < W; gi++) begin : g_fa
        assign o_count[gi] = w_a[gi] ^ w_b[gi] ^ w_c[gi];
        if (gi < W - 1) begin : g_carry
          assign w_c[gi+1] = (w_a[gi] & w_b[gi]) | (w_a[gi] & w_c[gi]) | (w_b[gi] & w_c[gi]);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount: chunk counts in S1, word sum / frame accumulation in S2,
// valid/ready on both sides with a single global stall.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter int MAX_BEATS = 256
) (
  input  logic                                  CLK,
  input  logic                                  ASYNCRESETN,
  input  logic                                  clr,
  input  logic [WIDTH-1:0]                      I_data,
  input  logic                                  I_mode,
  input  logic                                  I_last,
  input  logic                                  I_valid,
  output logic                                  I_ready,
  output logic [cnt_width(WIDTH,MAX_BEATS)-1:0] O_count,
  output logic [beat_width(MAX_BEATS)-1:0]      O_beats,
  output logic                                  O_trunc,
  output logic                                  O_valid,
  input  logic                                  O_ready
);

  localparam int CNT_W  = cnt_width(WIDTH, MAX_BEATS);
  localparam int BEAT_W = beat_width(MAX_BEATS);
  localparam int NCH    = WIDTH / CHUNK;
  localparam int CW     = clog2(CHUNK + 1);

  logic                     w_stall;
  logic                     w_accept;
  logic [NCH-1:0][CW-1:0]   w_chunk_cnt;

  logic                     r_s1_valid;
  logic [NCH-1:0][CW-1:0]   r_s1_cnt;
  logic                     r_s1_mode;
  logic                     r_s1_last;

  logic [CNT_W-1:0]         r_acc;
  logic [BEAT_W-1:0]        r_beats;
  logic [CNT_W-1:0]         r_o_count;
  logic [BEAT_W-1:0]        r_o_beats;
  logic                     r_o_trunc;
  logic                     r_o_valid;

  logic [CNT_W-1:0]         w_word_sum;
  logic [CNT_W-1:0]         w_frame_sum;
  logic [BEAT_W-1:0]        w_frame_beats;
  logic                     w_emit;
  logic [CNT_W-1:0]         w_acc_next;
  logic [BEAT_W-1:0]        w_beats_next;
  logic [CNT_W-1:0]         w_out_count;
  logic [BEAT_W-1:0]        w_out_beats;
  logic                     w_out_trunc;

  assign w_stall  = r_o_valid & ~O_ready;
  assign I_ready  = ~w_stall;
  assign w_accept = I_valid & I_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      popcount_chunk #(.N(CHUNK)) u_chunk (
        .i_bits  (I_data[gi*CHUNK +: CHUNK]),
        .o_count (w_chunk_cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    w_word_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      w_word_sum = w_word_sum + CNT_W'(r_s1_cnt[k]);
    end
  end

  assign w_frame_sum   = r_acc + w_word_sum;
  assign w_frame_beats = r_beats + BEAT_W'(1);

  // Word beats bypass the open frame entirely, so frames may interleave with words.
  always_comb begin
    w_emit       = 1'b0;
    w_acc_next   = r_acc;
    w_beats_next = r_beats;
    w_out_count  = r_o_count;
    w_out_beats  = r_o_beats;
    w_out_trunc  = r_o_trunc;
    if (r_s1_valid) begin
      unique case (r_s1_mode)
        MODE_WORD: begin
          w_emit      = 1'b1;
          w_out_count = w_word_sum;
          w_out_beats = BEAT_W'(1);
          w_out_trunc = 1'b0;
        end
        MODE_FRAME: begin
          if (r_s1_last || (w_frame_beats == BEAT_W'(MAX_BEATS))) begin
            w_emit       = 1'b1;
            w_out_count  = w_frame_sum;
            w_out_beats  = w_frame_beats;
            w_out_trunc  = ~r_s1_last;
            w_acc_next   = '0;
            w_beats_next = '0;
          end else begin
            w_acc_next   = w_frame_sum;
            w_beats_next = w_frame_beats;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_s1_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_acc      <= '0;
      r_beats    <= '0;
      r_o_count  <= '0;
      r_o_beats  <= '0;
      r_o_trunc  <= 1'b0;
      r_o_valid  <= 1'b0;
    end else if (clr) begin
      r_s1_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_acc      <= '0;
      r_beats    <= '0;
      r_o_count  <= '0;
      r_o_beats  <= '0;
      r_o_trunc  <= 1'b0;
      r_o_valid  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_cnt  <= w_chunk_cnt;
        r_s1_mode <= I_mode;
        r_s1_last <= I_last;
      end
      r_acc     <= w_acc_next;
      r_beats   <= w_beats_next;
      r_o_valid <= w_emit;
      r_o_count <= w_out_count;
      r_o_beats <= w_out_beats;
      r_o_trunc <= w_out_trunc;
    end
  end

  assign O_count = r_o_count;
  assign O_beats = r_o_beats;
  assign O_trunc = r_o_trunc;
  assign O_valid = r_o_valid;

endmodule

// File: tb/tb_popcount_stream.sv
// Directed bench for popcount_stream (WIDTH=32, CHUNK=8, MAX_BEATS=4) with an output scoreboard.
module tb_popcount_stream;
  import popcount_pkg::*;

  localparam int WIDTH     = 32;
  localparam int CHUNK     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 8;
  localparam int BEAT_W    = 3;

  logic              CLK;
  logic              ASYNCRESETN;
  logic              clr;
  logic [WIDTH-1:0]  I_data;
  logic              I_mode;
  logic              I_last;
  logic              I_valid;
  logic              I_ready;
  logic [CNT_W-1:0]  O_count;
  logic [BEAT_W-1:0] O_beats;
  logic              O_trunc;
  logic              O_valid;
  logic              O_ready;

  popcount_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK), .MAX_BEATS(MAX_BEATS)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr),
    .I_data(I_data), .I_mode(I_mode), .I_last(I_last), .I_valid(I_valid), .I_ready(I_ready),
    .O_count(O_count), .O_beats(O_beats), .O_trunc(O_trunc), .O_valid(O_valid), .O_ready(O_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc_cyc = 0;
  int stall_cycles = 0;
  int q_cnt[$];
  int q_beats[$];
  int q_trunc[$];
  int q_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Scoreboard capture and stall-hold checks, sampled mid-cycle.
  initial begin
    logic             prev_stall;
    logic [CNT_W-1:0] prev_count;
    prev_stall = 1'b0;
    prev_count = '0;
    forever begin
      @(negedge CLK);
      if (O_valid && O_ready) begin
        q_cnt.push_back(int'(O_count));
        q_beats.push_back(int'(O_beats));
        q_trunc.push_back(int'(O_trunc));
        q_cyc.push_back(cyc);
        $display("[TB] out count=%0d beats=%0d trunc=%0d cyc=%0d", O_count, O_beats, O_trunc, cyc);
      end
      if (O_valid && !O_ready) begin
        stall_cycles++;
        check("stall_i_ready", I_ready, 0);
        if (prev_stall) check("stall_hold", O_count, prev_count);
        prev_stall = 1'b1;
        prev_count = O_count;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic m, input logic l);
    int n;
    I_data  = d;
    I_mode  = m;
    I_last  = l;
    I_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!I_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("send_timeout", I_ready, 1);
    @(posedge CLK);
    #1;
    last_acc_cyc = cyc;
    I_valid = 1'b0;
    $display("[TB] beat data=%h mode=%0d last=%0d acc_cyc=%0d", d, m, l, cyc);
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic clear_q();
    q_cnt.delete();
    q_beats.delete();
    q_trunc.delete();
    q_cyc.delete();
  endtask

  task automatic expect_out(input string tag, input int idx, input int c, input int b, input int t);
    if (idx < q_cnt.size()) begin
      check({tag, "_count"}, q_cnt[idx], c);
      check({tag, "_beats"}, q_beats[idx], b);
      check({tag, "_trunc"}, q_trunc[idx], t);
    end
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    clr     = 1'b0;
    I_data  = '0;
    I_mode  = MODE_WORD;
    I_last  = 1'b0;
    I_valid = 1'b0;
    O_ready = 1'b1;
    repeat (2) tick();
    check("rst_o_valid", O_valid, 0);
    check("rst_o_count", O_count, 0);
    check("rst_o_beats", O_beats, 0);
    check("rst_o_trunc", O_trunc, 0);
    check("rst_i_ready", I_ready, 1);
    ASYNCRESETN = 1'b1;
    tick();

    // Word mode back-to-back
    begin
      int a0;
      clear_q();
      send(32'hFFFF_FFFF, MODE_WORD, 1'b0);
      a0 = last_acc_cyc;
      send(32'h0000_0000, MODE_WORD, 1'b0);
      send(32'h8000_0001, MODE_WORD, 1'b0);
      drain();
      check("word_n", q_cnt.size(), 3);
      expect_out("word0", 0, 32, 1, 0);
      expect_out("word1", 1, 0, 1, 0);
      expect_out("word2", 2, 2, 1, 0);
      if (q_cyc.size() >= 3) begin
        check("word_latency", q_cyc[0], a0 + 1);
        check("word_b2b_1", q_cyc[1], q_cyc[0] + 1);
        check("word_b2b_2", q_cyc[2], q_cyc[0] + 2);
      end
    end

    // Frame accumulation
    clear_q();
    send(32'h0000_000F, MODE_FRAME, 1'b0);
    send(32'h0000_00FF, MODE_FRAME, 1'b0);
    send(32'hFFFF_FFFF, MODE_FRAME, 1'b1);
    drain();
    check("frame_n", q_cnt.size(), 1);
    expect_out("frame", 0, 44, 3, 0);

    // Forced close at MAX_BEATS
    clear_q();
    for (int i = 0; i < 5; i++) send(32'h0000_0001, MODE_FRAME, i == 4);
    drain();
    check("trunc_n", q_cnt.size(), 2);
    expect_out("trunc0", 0, 4, 4, 1);
    expect_out("trunc1", 1, 1, 1, 0);

    // Backpressure: O_ready low for five cycles
    clear_q();
    stall_cycles = 0;
    fork
      begin
        logic [31:0] d;
        d = 32'h1;
        for (int i = 0; i < 6; i++) begin
          send(d, MODE_WORD, 1'b0);
          d = (d << 1) | 32'h1;
        end
      end
      begin
        repeat (3) @(posedge CLK);
        #2 O_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #2 O_ready = 1'b1;
      end
    join
    drain();
    check("bp_stalled", stall_cycles > 0, 1);
    check("bp_n", q_cnt.size(), 6);
    for (int i = 0; i < 6; i++) expect_out("bp", i, i + 1, 1, 0);

    // Word beat interleaved inside an open frame
    clear_q();
    send(32'h0000_0003, MODE_FRAME, 1'b0);
    send(32'h0000_000F, MODE_WORD, 1'b0);
    send(32'h0000_0001, MODE_FRAME, 1'b1);
    drain();
    check("ilv_n", q_cnt.size(), 2);
    expect_out("ilv0", 0, 4, 1, 0);
    expect_out("ilv1", 1, 3, 2, 0);

    // Asynchronous reset mid-frame with a held output
    clear_q();
    send(32'h0000_00FF, MODE_FRAME, 1'b0);
    send(32'h0000_00FF, MODE_FRAME, 1'b0);
    O_ready = 1'b0;
    send(32'h0000_0001, MODE_WORD, 1'b0);
    tick();
    tick();
    check("arst_pre_valid", O_valid, 1);
    #3 ASYNCRESETN = 1'b0;
    #1;
    check("arst_o_valid", O_valid, 0);
    check("arst_o_count", O_count, 0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    O_ready = 1'b1;
    tick();
    send(32'h0000_0003, MODE_FRAME, 1'b1);
    drain();
    check("arst_n", q_cnt.size(), 1);
    expect_out("arst", 0, 2, 1, 0);

    // Synchronous clear mid-frame with a held output
    clear_q();
    send(32'h0000_00FF, MODE_FRAME, 1'b0);
    send(32'h0000_00FF, MODE_FRAME, 1'b0);
    O_ready = 1'b0;
    send(32'h0000_0001, MODE_WORD, 1'b0);
    tick();
    tick();
    check("clr_pre_valid", O_valid, 1);
    clr = 1'b1;
    tick();
    check("clr_o_valid", O_valid, 0);
    check("clr_o_beats", O_beats, 0);
    clr = 1'b0;
    O_ready = 1'b1;
    send(32'h0000_0003, MODE_FRAME, 1'b1);
    drain();
    check("clr_n", q_cnt.size(), 1);
    expect_out("clr", 0, 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
